// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: stage FSM encoding and the legal memory-latency range.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   // Out-of-range latencies are pulled to the nearest legal value so the 2-bit counter never overflows.
   function automatic int clamp_latency(input int lat);
      if (lat < LAT_MIN) return LAT_MIN;
      if (lat > LAT_MAX) return LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Word-addressed data array: asynchronous read, rising-edge write with enable.
module data_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory access FSM with stall, misalignment detection and MEM/WB pass-through.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [4:0]  mrn,
   input  logic [31:0] malu,
   input  logic [31:0] mb,
   output logic        mwreg_o,
   output logic        mm2reg_o,
   output logic [4:0]  mrn_o,
   output logic [31:0] mr,
   output logic [31:0] mdo,
   output logic        mem_stall,
   output logic        misalign
);

   localparam int         AW   = $clog2(DEPTH);
   localparam int         LAT  = clamp_latency(LATENCY);
   localparam logic [1:0] LAST = 2'(LAT - 1);

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic        req, mis, active, final_cyc;
   logic        is_store, is_load, we;
   logic [AW-1:0] idx;
   logic [31:0] rdata;

   // A request is only recognised from IDLE; in BUSY the held inputs are just the operands of the access in flight.
   assign req      = (state == IDLE) && (mwmem || mm2reg);
   assign mis      = req && (malu[1:0] != 2'b00);
   assign is_store = mwmem;
   assign is_load  = mm2reg && !mwmem;
   assign idx      = malu[AW+1:2];

   assign active    = (state == BUSY) || (req && !mis);
   assign final_cyc = (LAT == 1) ? active : ((state == BUSY) && (cnt == LAST));

   assign mem_stall = active && !final_cyc;
   // Gating with clrn keeps a reset landing on the final cycle from committing the store.
   assign we        = final_cyc && is_store && clrn;
   assign mdo       = (final_cyc && is_load) ? rdata : 32'h0;

   assign mwreg_o  = mwreg && !mis;
   assign mm2reg_o = mm2reg;
   assign mrn_o    = mrn;
   assign mr       = malu;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req && !mis && (LAT > 1)) begin
               state_nxt = BUSY;
               cnt_nxt   = 2'd1;
            end
         end
         BUSY: begin
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         misalign <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         misalign <= mis;
      end
   end

   data_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_data_ram (
      .clk   (clk),
      .we    (we),
      .addr  (idx),
      .wdata (mb),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances at LATENCY 1, 2 and 3 sharing clock and reset.
module tb_mem_stage;

   logic clk = 1'b0;
   logic clrn;
   always #5 clk = ~clk;

   logic        mwreg    [3];
   logic        mm2reg   [3];
   logic        mwmem    [3];
   logic [4:0]  mrn      [3];
   logic [31:0] malu     [3];
   logic [31:0] mb       [3];
   logic        mwreg_o  [3];
   logic        mm2reg_o [3];
   logic [4:0]  mrn_o    [3];
   logic [31:0] mr       [3];
   logic [31:0] mdo      [3];
   logic        mem_stall[3];
   logic        misalign [3];

   int errors = 0;
   int checks = 0;

   // Instance g has LATENCY g+1.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_stage #(
         .DEPTH   (256),
         .LATENCY (g + 1)
      ) u_dut (
         .clk       (clk),
         .clrn      (clrn),
         .mwreg     (mwreg[g]),
         .mm2reg    (mm2reg[g]),
         .mwmem     (mwmem[g]),
         .mrn       (mrn[g]),
         .malu      (malu[g]),
         .mb        (mb[g]),
         .mwreg_o   (mwreg_o[g]),
         .mm2reg_o  (mm2reg_o[g]),
         .mrn_o     (mrn_o[g]),
         .mr        (mr[g]),
         .mdo       (mdo[g]),
         .mem_stall (mem_stall[g]),
         .misalign  (misalign[g])
      );
   end

   task automatic drive(input int u, input logic st, input logic ld, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      mwmem[u]  = st;
      mm2reg[u] = ld;
      mwreg[u]  = wr;
      malu[u]   = a;
      mb[u]     = d;
      mrn[u]    = a[6:2];
   endtask

   task automatic idle(input int u);
      drive(u, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b1, 1'b1, 32'h1, 32'h0);
      @(negedge clk);
      for (int u = 0; u < 3; u++) idle(u);
      #1;
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (mem_stall[u] !== 1'b0) begin errors++; $display("FAIL rst_stall[%0d] got=%b exp=0", u, mem_stall[u]); end
         checks++;
         if (mdo[u] !== 32'h0) begin errors++; $display("FAIL rst_mdo[%0d] got=%h exp=0", u, mdo[u]); end
         checks++;
         if (misalign[u] !== 1'b0) begin errors++; $display("FAIL rst_misalign[%0d] got=%b exp=0", u, misalign[u]); end
      end
      @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic test_store_load();
      logic        exp_stall [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] exp_mdo   [4] = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 2) drive(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
         else       drive(1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
         #1;
         checks++;
         if (mem_stall[1] !== exp_stall[i]) begin errors++; $display("FAIL l2_stall[%0d] got=%b exp=%b", i, mem_stall[1], exp_stall[i]); end
         checks++;
         if (mdo[1] !== exp_mdo[i]) begin errors++; $display("FAIL l2_mdo[%0d] got=%h exp=%h", i, mdo[1], exp_mdo[i]); end
      end
      checks++;
      if (mr[1] !== 32'h10) begin errors++; $display("FAIL pass_mr got=%h exp=00000010", mr[1]); end
      checks++;
      if (mrn_o[1] !== 5'd4) begin errors++; $display("FAIL pass_mrn got=%0d exp=4", mrn_o[1]); end
      checks++;
      if (mwreg_o[1] !== 1'b1 || mm2reg_o[1] !== 1'b1) begin
         errors++; $display("FAIL pass_ctl got=%b%b exp=11", mwreg_o[1], mm2reg_o[1]);
      end
      @(negedge clk);
      idle(1);
      #1;
      checks++;
      if (mdo[1] !== 32'h0 || mem_stall[1] !== 1'b0) begin
         errors++; $display("FAIL l2_after mdo=%h stall=%b exp=0/0", mdo[1], mem_stall[1]);
      end
   endtask

   task automatic test_misalign();
      logic exp_mis [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0)      drive(1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0);
         else if (i == 1) drive(1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hBAD0BAD0);
         else             idle(1);
         #1;
         checks++;
         if (misalign[1] !== exp_mis[i]) begin errors++; $display("FAIL mis_flag[%0d] got=%b exp=%b", i, misalign[1], exp_mis[i]); end
         if (i == 0) begin
            checks++;
            if (mem_stall[1] !== 1'b0) begin errors++; $display("FAIL mis_stall got=%b exp=0", mem_stall[1]); end
            checks++;
            if (mdo[1] !== 32'h0) begin errors++; $display("FAIL mis_mdo got=%h exp=0", mdo[1]); end
            checks++;
            if (mwreg_o[1] !== 1'b0) begin errors++; $display("FAIL mis_mwreg got=%b exp=0", mwreg_o[1]); end
         end
         if (i == 1) begin
            checks++;
            if (mem_stall[1] !== 1'b0) begin errors++; $display("FAIL mis_st_stall got=%b exp=0", mem_stall[1]); end
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
         #1;
      end
      checks++;
      if (mdo[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem_kept got=%h exp=deadbeef", mdo[1]); end
      @(negedge clk);
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic        exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] exp_mdo   [6] = '{32'h0, 32'h0, 32'h11111111, 32'h0, 32'h0, 32'h22222222};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(2, 1'b1, 1'b0, 1'b0, (i < 3) ? 32'h0 : 32'h4, (i < 3) ? 32'h11111111 : 32'h22222222);
         #1;
         checks++;
         if (mem_stall[2] !== exp_stall[i]) begin errors++; $display("FAIL b2b_st_stall[%0d] got=%b exp=%b", i, mem_stall[2], exp_stall[i]); end
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(2, 1'b0, 1'b1, 1'b1, (i < 3) ? 32'h0 : 32'h4, 32'h0);
         #1;
         checks++;
         if (mem_stall[2] !== exp_stall[i]) begin errors++; $display("FAIL b2b_ld_stall[%0d] got=%b exp=%b", i, mem_stall[2], exp_stall[i]); end
         checks++;
         if (mdo[2] !== exp_mdo[i]) begin errors++; $display("FAIL b2b_ld_mdo[%0d] got=%h exp=%h", i, mdo[2], exp_mdo[i]); end
      end
      @(negedge clk);
      idle(2);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 2) drive(1, 1'b1, 1'b0, 1'b0, 32'h400, 32'hCAFEF00D);
         else       drive(1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
         #1;
      end
      checks++;
      if (mdo[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_mdo got=%h exp=cafef00d", mdo[1]); end
      @(negedge clk);
      idle(1);
   endtask

   task automatic test_latency1();
      logic        st   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        ld   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] addr [4] = '{32'h8, 32'h8, 32'hC, 32'hC};
      logic [31:0] dat  [4] = '{32'h0BADCAFE, 32'h0, 32'h55, 32'h0};
      logic [31:0] exp_mdo [4] = '{32'h0, 32'h0BADCAFE, 32'h0, 32'h55};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(0, st[i], ld[i], 1'b1, addr[i], dat[i]);
         #1;
         checks++;
         if (mem_stall[0] !== 1'b0) begin errors++; $display("FAIL l1_stall[%0d] got=%b exp=0", i, mem_stall[0]); end
         checks++;
         if (mdo[0] !== exp_mdo[i]) begin errors++; $display("FAIL l1_mdo[%0d] got=%h exp=%h", i, mdo[0], exp_mdo[i]); end
      end
      @(negedge clk);
      idle(0);
   endtask

   task automatic test_reset_abort();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(2, 1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678);
         if (i < 2) drive(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h01010101);
         else       idle(1);
      end
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 1'b0, 32'h20, 32'hFFFF0000);
      drive(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'hAAAA5555);
      #1;
      checks++;
      if (mem_stall[2] !== 1'b1 || mem_stall[1] !== 1'b1) begin
         errors++; $display("FAIL abort_req_stall got=%b%b exp=11", mem_stall[2], mem_stall[1]);
      end
      @(negedge clk);
      clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      idle(1);
      idle(2);
      #1;
      checks++;
      if (mem_stall[2] !== 1'b0 || mem_stall[1] !== 1'b0) begin
         errors++; $display("FAIL abort_idle_stall got=%b%b exp=00", mem_stall[2], mem_stall[1]);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(2, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0);
         if (i < 2) drive(1, 1'b0, 1'b1, 1'b1, 32'h30, 32'h0);
         else       idle(1);
         #1;
         if (i == 1) begin
            checks++;
            if (mdo[1] !== 32'h01010101) begin errors++; $display("FAIL abort_l2_mem got=%h exp=01010101", mdo[1]); end
         end
         if (i == 2) begin
            checks++;
            if (mdo[2] !== 32'h12345678) begin errors++; $display("FAIL abort_l3_mem got=%h exp=12345678", mdo[2]); end
         end
      end
      @(negedge clk);
      idle(2);
   endtask

   initial begin
      clrn = 1'b0;
      for (int u = 0; u < 3; u++) idle(u);
      test_reset();
      test_store_load();
      test_misalign();
      test_back_to_back();
      test_wrap();
      test_latency1();
      test_reset_abort();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL expose parameter DEPTH, default 256, meaning number of 32-bit data-memory words (power of two).
REQ-002 SHALL expose parameter LATENCY, default 2, meaning cycles per memory access (legal range 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports mwreg, mm2reg, mwmem  input  1 each  EX/MEM controls: register write, load, store.
REQ-006 SHALL have port mrn  input  5  destination register number.
REQ-007 SHALL have ports malu, mb  input  32 each  ALU result/address and store data.
REQ-008 SHALL have ports mwreg_o, mm2reg_o  output  1 each, and mrn_o  output  5, and mr  output  32: controls, register number and ALU result forwarded to MEM/WB.
REQ-009 SHALL have port mdo  output  32  load data.
REQ-010 SHALL have port mem_stall  output  1  pipeline freeze request.
REQ-011 SHALL have port misalign  output  1  registered misaligned-access flag.

Function
REQ-012 SHALL pass mwreg, mm2reg, mrn and malu combinationally to mwreg_o, mm2reg_o, mrn_o and mr; during a misaligned access mwreg_o SHALL be 0.
REQ-013 SHALL treat a cycle as a request when state is IDLE and (mwmem or mm2reg) is 1; if both are 1, the access SHALL be a store and mdo SHALL be 0.
REQ-014 SHALL form word index = malu[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-015 SHALL classify a request with malu[1:0] != 0 as misaligned: no stall, no array write, mdo = 0, and misalign = 1 on the following cycle.
REQ-016 SHALL implement states IDLE and BUSY with a 2-bit cycle counter cnt.
REQ-017 For LATENCY = 1, every aligned access SHALL complete in its request cycle, mem_stall SHALL stay 0, and state SHALL stay IDLE.
REQ-018 For LATENCY > 1, an aligned request SHALL move IDLE -> BUSY with cnt = 1.
REQ-019 In BUSY, cnt SHALL increment each cycle; when cnt reaches LATENCY-1, that cycle SHALL be the final cycle and the state SHALL return to IDLE on the next edge.
REQ-020 mem_stall SHALL be 1 in every cycle of an aligned access except the final one; it SHALL be asserted combinationally in the request cycle.
REQ-021 Upstream holds all inputs stable while mem_stall = 1; the block SHALL NOT re-latch or re-sample the request during BUSY.
REQ-022 A store SHALL write mb to the array exactly once, at the rising edge closing the final cycle.
REQ-023 For a load, mdo SHALL equal array[index] in the final cycle and SHALL be 0 in all other cycles.
REQ-024 A request present in the cycle after a final cycle SHALL start a new access from IDLE, with no idle bubble.
REQ-025 misalign SHALL be 1 for exactly one cycle per misaligned request and SHALL be cleared by the next non-misaligned cycle.

Reset
REQ-026 While clrn = 0 at a rising edge: state SHALL become IDLE, cnt 0 and misalign 0; mem_stall and mdo SHALL read 0 in the cycle after.
REQ-027 Reset asserted mid-access SHALL abort the access: no array write, and the pending store is lost.
REQ-028 Array contents SHALL NOT be affected by reset.

Structure
REQ-029 State encoding (IDLE, BUSY) and the LATENCY legal range SHALL be placed in a shared pipeline package used by all stage blocks.
REQ-030 The data array SHALL be a separate sub-module, data_ram: word-addressed, asynchronous read, rising-edge write with write enable; mem_stage SHALL hold the FSM and control.

Verification
REQ-031 LATENCY=2: store malu=0x10, mb=0xDEADBEEF -> mem_stall=1 for 1 cycle; then load malu=0x10 -> mdo=0xDEADBEEF in the final cycle, 0 otherwise.
REQ-032 LATENCY=3: back-to-back loads to 0x0 and 0x4 -> mem_stall pattern 1,1,0,1,1,0 and no idle cycle between the accesses.
REQ-033 Load malu=0x13 -> mem_stall=0, mdo=0, mwreg_o=0, misalign=1 for one cycle, and memory unchanged.
REQ-034 DEPTH=256: store to malu=0x400 followed by load from 0x0 -> same data (wrap).
REQ-035 LATENCY=3: clrn=0 during cycle 2 of a store to 0x20 -> state IDLE, and a later load of 0x20 returns the old contents.
REQ-036 LATENCY=1: store then load to 0x8 -> mem_stall never 1, and load data correct on the next cycle.
